// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS32 datapath: sequences fetch, decode,
// execute, memory and write-back, with mem_ready wait states on memory cycles.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned StateW = 4;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluRtyp = 3'b010;

  typedef enum logic [StateW-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  state_e state_q, state_d;

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OpLw, OpSw: state_d = S_MEMADR;
          OpRtype:    state_d = S_EXEC;
          OpBeq:      state_d = S_BRANCH;
          OpJ:        state_d = S_JUMP;
          default:    state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OpSw) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = AluAdd;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        AluSrcB = 2'b11;
        case (Opcode)
          OpLw, OpSw, OpRtype, OpBeq, OpJ: illegal = 1'b0;
          default:                         illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        AluSrcA = 1'b1;
        AluOp   = AluRtyp;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        AluOp    = AluRtyp;
      end
      S_BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = AluSub;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign state = StateW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks state plus every control output.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, AluSrcA, illegal;
  logic [1:0] AluSrcB, PCSource;
  logic [2:0] AluOp;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .PCSource(PCSource), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [17:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp,
                 PCSource, illegal};

  // Build an expected output vector in the same field order as outs.
  function automatic logic [17:0] mk(input logic pcw, input logic pcwc,
      input logic iord, input logic mr, input logic mw, input logic irw,
      input logic mtr, input logic rd, input logic rw, input logic sa,
      input logic [1:0] sb, input logic [2:0] op, input logic [1:0] ps,
      input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, mtr, rd, rw, sa, sb, op, ps, ill};
  endfunction

  logic [17:0] e_idle, e_fetch, e_fstall, e_decode, e_illegal, e_memadr;
  logic [17:0] e_memrd, e_memwb, e_memwr, e_exec, e_rwb, e_branch, e_jump;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] es, input logic [17:0] eo);
    #1;
    checks++;
    assert (state === es) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, es);
    end
    checks++;
    assert (outs === eo) else begin
      errors++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, outs, eo);
    end
  endtask

  initial begin
    e_idle    = '0;
    e_fetch   = mk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,2'b00,0);
    e_fstall  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0);
    e_decode  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0);
    e_illegal = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,1);
    e_memadr  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0);
    e_memrd   = mk(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
    e_memwb   = mk(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0);
    e_memwr   = mk(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0);
    e_exec    = mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0);
    e_rwb     = mk(0,0,0,0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0);
    e_branch  = mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0);
    e_jump    = mk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0);

    rst_n = 1'b0; mem_ready = 1'b1; Opcode = 6'b000000;

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", 4'd0, e_idle);
    end
    rst_n = 1'b1;
    chk("idle_after_release", 4'd0, e_idle);
    tick(); chk("first_fetch", 4'd1, e_fetch);

    // R-type: 1,2,7,8,1
    tick(); chk("rt_decode", 4'd2, e_decode);
    tick(); chk("rt_exec", 4'd7, e_exec);
    tick(); chk("rt_rwb", 4'd8, e_rwb);
    tick(); chk("rt_fetch", 4'd1, e_fetch);

    // lw with two wait states in MEMRD
    Opcode = 6'b100011;
    tick(); chk("lw_decode", 4'd2, e_decode);
    tick(); mem_ready = 1'b0; chk("lw_memadr", 4'd3, e_memadr);
    tick(); chk("lw_memrd_w1", 4'd4, e_memrd);
    tick(); chk("lw_memrd_w2", 4'd4, e_memrd);
    tick(); mem_ready = 1'b1; chk("lw_memrd_rdy", 4'd4, e_memrd);
    tick(); chk("lw_memwb", 4'd5, e_memwb);
    tick(); Opcode = 6'b000100; chk("lw_fetch", 4'd1, e_fetch);

    // beq, with one FETCH wait state first
    mem_ready = 1'b0; chk("fetch_stall", 4'd1, e_fstall);
    tick(); mem_ready = 1'b1; chk("fetch_after_stall", 4'd1, e_fetch);
    tick(); chk("beq_decode", 4'd2, e_decode);
    tick(); chk("beq_branch", 4'd9, e_branch);
    tick(); Opcode = 6'b000010; chk("beq_fetch", 4'd1, e_fetch);

    // j
    tick(); chk("j_decode", 4'd2, e_decode);
    tick(); chk("j_jump", 4'd10, e_jump);
    tick(); Opcode = 6'b111111; chk("j_fetch", 4'd1, e_fetch);

    // illegal opcode: one-cycle pulse, straight back to FETCH
    tick(); chk("ill_decode", 4'd2, e_illegal);
    tick(); Opcode = 6'b101011; chk("ill_fetch", 4'd1, e_fetch);

    // sw stalled in MEMWR, then reset drops the write
    tick(); chk("sw_decode", 4'd2, e_decode);
    tick(); mem_ready = 1'b0; chk("sw_memadr", 4'd3, e_memadr);
    tick(); chk("sw_memwr_w1", 4'd6, e_memwr);
    tick(); rst_n = 1'b0; chk("sw_memwr_w2", 4'd6, e_memwr);
    tick(); chk("sw_reset_abort", 4'd0, e_idle);
    rst_n = 1'b1; mem_ready = 1'b1;
    tick(); chk("refetch", 4'd1, e_fetch);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
